// File: rtl/data_cache_pkg.sv
// Shared types and address helpers for the direct-mapped write-through data cache.
package data_cache_pkg;

  localparam int INDEX_BITS_DEFAULT = 6;
  localparam int TAG_BITS           = 30 - INDEX_BITS_DEFAULT;
  localparam int LINES              = 2 ** INDEX_BITS_DEFAULT;

  typedef enum logic [1:0] {
    IDLE,
    RD_MISS,
    WR_THRU
  } state_t;

  function automatic logic [31:0] index_of(input logic [31:0] addr, input int index_bits);
    return (addr >> 2) & ((32'd1 << index_bits) - 32'd1);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] addr, input int index_bits);
    return addr >> (index_bits + 2);
  endfunction

endpackage

// File: rtl/cache_line_array.sv
// Tag/valid/data storage: combinational read port, synchronous write port, async valid clear.
module cache_line_array
  import data_cache_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_BITS_DEFAULT,
  parameter int TAG_W      = TAG_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [31:0]           rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [31:0]           wr_data
);

  localparam int DEPTH = 2 ** INDEX_BITS;

  logic [DEPTH-1:0] valid;
  logic [TAG_W-1:0] tags [DEPTH];
  logic [31:0]      data [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // Tag and data need no reset: a cleared valid bit masks them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_index] <= wr_tag;
      data[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_data  = data[rd_index];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MEM stage.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_BITS_DEFAULT,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          ADDRESS,
  input  logic [31:0]          WRITE_DATA,
  input  logic                 MEM_READ,
  input  logic                 MEM_WRITE,
  output logic [31:0]          READ_DATA,
  output logic                 HIT,
  output logic                 STALL,
  output logic                 MM_REQ,
  output logic                 MM_WE,
  output logic [31:0]          MM_ADDR,
  output logic [31:0]          MM_WDATA,
  input  logic [31:0]          MM_RDATA,
  input  logic                 MM_ACK,
  output logic [CNT_WIDTH-1:0] HIT_COUNT,
  output logic [CNT_WIDTH-1:0] MISS_COUNT
);

  localparam int TAG_W = 30 - INDEX_BITS;

  state_t                state, state_next;
  logic [29:0]           addr_q;
  logic [31:0]           wdata_q;
  logic [CNT_WIDTH-1:0]  hit_cnt, miss_cnt;
  logic                  latch_addr, latch_data, hit_inc, miss_inc, arr_we;
  logic [31:0]           arr_wdata;
  logic [31:0]           look_addr;
  logic [INDEX_BITS-1:0] look_index;
  logic [TAG_W-1:0]      look_tag;
  logic                  line_valid;
  logic [TAG_W-1:0]      line_tag;
  logic [31:0]           line_data;
  logic                  line_hit;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Outside IDLE the lookup uses the latched request, so the write-through hit check sees the stored address.
  assign look_addr  = (state == IDLE) ? ADDRESS : {addr_q, 2'b00};
  assign look_index = INDEX_BITS'(index_of(look_addr, INDEX_BITS));
  assign look_tag   = TAG_W'(tag_of(look_addr, INDEX_BITS));
  assign line_hit   = line_valid && (line_tag == look_tag);

  cache_line_array #(
    .INDEX_BITS(INDEX_BITS),
    .TAG_W     (TAG_W)
  ) u_lines (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_index(look_index),
    .rd_valid(line_valid),
    .rd_tag  (line_tag),
    .rd_data (line_data),
    .wr_en   (arr_we),
    .wr_index(look_index),
    .wr_tag  (look_tag),
    .wr_data (arr_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      state <= state_next;
      if (latch_addr) addr_q  <= ADDRESS[31:2];
      if (latch_data) wdata_q <= WRITE_DATA;
      if (hit_inc)    hit_cnt  <= sat_inc(hit_cnt);
      if (miss_inc)   miss_cnt <= sat_inc(miss_cnt);
    end
  end

  always_comb begin
    state_next = state;
    READ_DATA  = '0;
    HIT        = 1'b0;
    STALL      = 1'b0;
    latch_addr = 1'b0;
    latch_data = 1'b0;
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;
    arr_we     = 1'b0;
    arr_wdata  = wdata_q;
    // Pipeline-facing outputs stay at their reset values while rst_n is low.
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (MEM_WRITE) begin
            STALL      = 1'b1;
            latch_addr = 1'b1;
            latch_data = 1'b1;
            state_next = WR_THRU;
          end else if (MEM_READ) begin
            if (line_hit) begin
              READ_DATA = line_data;
              HIT       = 1'b1;
              hit_inc   = 1'b1;
            end else begin
              STALL      = 1'b1;
              latch_addr = 1'b1;
              miss_inc   = 1'b1;
              state_next = RD_MISS;
            end
          end
        end
        RD_MISS: begin
          if (MM_ACK) begin
            READ_DATA  = MM_RDATA;
            arr_we     = 1'b1;
            arr_wdata  = MM_RDATA;
            state_next = IDLE;
          end else begin
            STALL = 1'b1;
          end
        end
        WR_THRU: begin
          if (MM_ACK) begin
            arr_we     = line_hit;
            state_next = IDLE;
          end else begin
            STALL = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign MM_REQ     = (state != IDLE);
  assign MM_WE      = (state == WR_THRU);
  assign MM_ADDR    = {addr_q, 2'b00};
  assign MM_WDATA   = wdata_q;
  assign HIT_COUNT  = hit_cnt;
  assign MISS_COUNT = miss_cnt;

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: directed scenarios followed by randomized loads/stores.
module tb_data_cache;

  localparam int IB    = 4;
  localparam int CW    = 4;
  localparam int LINES = 2 ** IB;
  localparam int CMAX  = 2 ** CW - 1;

  logic          clk, rst_n;
  logic [31:0]   ADDRESS, WRITE_DATA, READ_DATA, MM_ADDR, MM_WDATA, MM_RDATA;
  logic          MEM_READ, MEM_WRITE, HIT, STALL, MM_REQ, MM_WE, MM_ACK;
  logic [CW-1:0] HIT_COUNT, MISS_COUNT;

  data_cache #(.INDEX_BITS(IB), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ADDRESS(ADDRESS), .WRITE_DATA(WRITE_DATA),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .READ_DATA(READ_DATA), .HIT(HIT),
    .STALL(STALL), .MM_REQ(MM_REQ), .MM_WE(MM_WE), .MM_ADDR(MM_ADDR),
    .MM_WDATA(MM_WDATA), .MM_RDATA(MM_RDATA), .MM_ACK(MM_ACK),
    .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
  );

  typedef struct {
    bit          is_load;
    bit          hit;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic [31:0] maddr;
    int          stalls;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [logic [29:0]];
  logic [31:0] ext_mem [logic [29:0]];
  logic [29:0] line_addr [int];
  int          vectors = 0, miscompares = 0;
  int          exp_hit = 0, exp_miss = 0;
  int          cur_w = 0;
  bit          mon_en = 0, resp_en = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [29:0] wa);
    return {wa, 2'b01} ^ 32'hC3A5_0F0F;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [29:0] wa);
    return ref_mem.exists(wa) ? ref_mem[wa] : init_val(wa);
  endfunction

  function automatic logic [31:0] ext_rd(input logic [29:0] wa);
    return ext_mem.exists(wa) ? ext_mem[wa] : init_val(wa);
  endfunction

  function automatic logic [31:0] sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic preload(input logic [31:0] addr, input logic [31:0] val);
    ref_mem[addr[31:2]] = val;
    ext_mem[addr[31:2]] = val;
  endtask

  // Reference: memory is always the truth; the cache only decides hit/miss and stall cost.
  task automatic do_txn(input logic [31:0] addr, input bit rd, input bit wr,
                        input logic [31:0] wd, input int w);
    exp_t        e;
    logic [29:0] wa;
    int          idx, cyc;
    wa = addr[31:2];
    idx = int'(wa % LINES);
    e.maddr = {wa, 2'b00};
    e.wdata = wd;
    e.rdata = 32'd0;
    e.hit = 0;
    if (wr) begin
      e.is_load = 0;
      e.stalls = 1 + w;
      ref_mem[wa] = wd;
    end else begin
      e.is_load = 1;
      e.hit = line_addr.exists(idx) && (line_addr[idx] == wa);
      e.rdata = ref_rd(wa);
      if (e.hit) begin
        e.stalls = 0;
        exp_hit++;
      end else begin
        e.stalls = 1 + w;
        exp_miss++;
        line_addr[idx] = wa;
      end
    end
    sb.push_back(e);
    cur_w = w;
    ADDRESS = addr;
    WRITE_DATA = wd;
    MEM_READ = rd;
    MEM_WRITE = wr;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (!STALL) break;
      cyc++;
      if (cyc > 40) begin
        chk("txn_timeout", 32'(cyc), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    MEM_READ = 0;
    MEM_WRITE = 0;
    ADDRESS = $urandom;
    WRITE_DATA = $urandom;
  endtask

  // Monitor: a request completes in the first sampled cycle with STALL low.
  initial begin
    int   stall_cnt;
    exp_t e;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst_n && mon_en && (MEM_READ || MEM_WRITE)) begin
        if (STALL) begin
          stall_cnt++;
        end else begin
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL sb_empty: response with no expected entry at %0t", $time);
          end else begin
            e = sb.pop_front();
            chk("hit", {31'd0, HIT}, {31'd0, e.hit});
            chk("read_data", READ_DATA, e.rdata);
            chk("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
          end
          stall_cnt = 0;
        end
      end
    end
  end

  // Main-memory responder: acks after cur_w waiting cycles, checks the request it sees.
  initial begin
    int waitc;
    waitc = 0;
    MM_ACK = 0;
    MM_RDATA = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!resp_en) begin
        waitc = 0;
      end else if (MM_ACK) begin
        MM_ACK = 0;
        waitc = 0;
        MM_RDATA = $urandom;
      end else if (MM_REQ) begin
        if (waitc == 0 && sb.size() > 0) begin
          chk("mm_we", {31'd0, MM_WE}, {31'd0, !sb[0].is_load});
          chk("mm_addr", MM_ADDR, sb[0].maddr);
          if (!sb[0].is_load) chk("mm_wdata", MM_WDATA, sb[0].wdata);
        end
        if (waitc >= cur_w) begin
          MM_ACK = 1;
          if (MM_WE) ext_mem[MM_ADDR[31:2]] = MM_WDATA;
          else MM_RDATA = ext_rd(MM_ADDR[31:2]);
        end else begin
          waitc++;
        end
      end else begin
        MM_RDATA = $urandom;
      end
    end
  end

  initial begin
    logic [31:0] a;
    int          kind;
    rst_n = 0;
    ADDRESS = 0;
    WRITE_DATA = 0;
    MEM_READ = 0;
    MEM_WRITE = 0;
    #3;
    chk("rst_read_data", READ_DATA, 32'd0);
    chk("rst_hit", {31'd0, HIT}, 32'd0);
    chk("rst_stall", {31'd0, STALL}, 32'd0);
    chk("rst_mm_req", {31'd0, MM_REQ}, 32'd0);
    chk("rst_mm_we", {31'd0, MM_WE}, 32'd0);
    chk("rst_mm_addr", MM_ADDR, 32'd0);
    chk("rst_mm_wdata", MM_WDATA, 32'd0);
    chk("rst_counts", {HIT_COUNT, MISS_COUNT}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    mon_en = 1;
    resp_en = 1;

    // Directed scenarios
    preload(32'h40, 32'hDEAD_BEEF);
    do_txn(32'h40, 1, 0, 32'd0, 2);
    chk("miss_count_cold", 32'(MISS_COUNT), 32'd1);
    do_txn(32'h40, 1, 0, 32'd0, 0);
    chk("hit_count_first", 32'(HIT_COUNT), 32'd1);
    do_txn(32'h40, 0, 1, 32'h1234_5678, 0);
    do_txn(32'h40, 1, 0, 32'd0, 1);
    do_txn(32'h80, 0, 1, 32'hA0A0_5151, 1);
    do_txn(32'h80, 1, 0, 32'd0, 1);
    chk("miss_count_noalloc", 32'(MISS_COUNT), 32'd2);
    do_txn(32'h40, 1, 0, 32'd0, 1);
    do_txn(32'h40 + 4 * LINES, 1, 0, 32'd0, 0);
    do_txn(32'h40, 1, 0, 32'd0, 3);
    chk("miss_count_conflict", 32'(MISS_COUNT), sat(exp_miss));
    do_txn(32'h40, 1, 1, 32'hCAFE_F00D, 1);
    do_txn(32'h40, 1, 0, 32'd0, 0);
    chk("hit_count_directed", 32'(HIT_COUNT), sat(exp_hit));

    // Reset in the middle of a read miss, with a stray ack after release
    mon_en = 0;
    resp_en = 0;
    ADDRESS = 32'h44;
    MEM_READ = 1;
    @(negedge clk);
    chk("miss_stall", {31'd0, STALL}, 32'd1);
    @(posedge clk);
    #1;
    chk("miss_mm_req", {31'd0, MM_REQ}, 32'd1);
    @(negedge clk);
    rst_n = 0;
    MEM_READ = 0;
    #1;
    chk("midrst_mm_req", {31'd0, MM_REQ}, 32'd0);
    chk("midrst_mm_addr", MM_ADDR, 32'd0);
    chk("midrst_mm_wdata", MM_WDATA, 32'd0);
    chk("midrst_outputs", {READ_DATA[29:0], HIT, STALL}, 32'd0);
    chk("midrst_counts", {HIT_COUNT, MISS_COUNT}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    MM_ACK = 1;
    MM_RDATA = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("stray_ack_req", {31'd0, MM_REQ}, 32'd0);
    chk("stray_ack_out", {READ_DATA[29:0], HIT, STALL}, 32'd0);
    @(posedge clk);
    #1;
    MM_ACK = 0;
    chk("stray_ack_idle", {31'd0, MM_REQ}, 32'd0);
    line_addr.delete();
    sb.delete();
    exp_hit = 0;
    exp_miss = 0;
    mon_en = 1;
    resp_en = 1;
    do_txn(32'h40, 1, 0, 32'd0, 1);
    chk("miss_after_reset", 32'(MISS_COUNT), 32'd1);

    // Randomized traffic over a small, aliasing address pool
    for (int n = 0; n < 250; n++) begin
      a = (32'($urandom_range(0, 1)) << 30) | (32'($urandom_range(0, 47)) << 2) |
          32'($urandom_range(0, 3));
      kind = $urandom_range(0, 99);
      if (kind < 50) do_txn(a, 1, 0, $urandom, $urandom_range(0, 3));
      else if (kind < 85) do_txn(a, 0, 1, $urandom, $urandom_range(0, 3));
      else do_txn(a, 1, 1, $urandom, $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
    end
    chk("hit_count_final", 32'(HIT_COUNT), sat(exp_hit));
    chk("miss_count_final", 32'(MISS_COUNT), sat(exp_miss));
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Responder for the MEM-stage data port: accepts MEM_READ/MEM_WRITE requests and returns READ_DATA, HIT and STALL.
- Direct-mapped, write-through, no-write-allocate, one word per line.
- Sits between the MEM stage and a handshaked main-memory port (MM_*); reports hit/miss counts for performance checks.

Parameters:
- INDEX_BITS, 6, number of index bits; line count is 2**INDEX_BITS.
- CNT_WIDTH, 16, width of the saturating hit and miss counters.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- ADDRESS  in  32  byte address; [1:0] ignored; index = [INDEX_BITS+1:2]; tag = [31:INDEX_BITS+2].
- WRITE_DATA  in  32  store data.
- MEM_READ  in  1  load request.
- MEM_WRITE  in  1  store request; wins over MEM_READ when both are high.
- READ_DATA  out  32  load data.
- HIT  out  1  load request hit in the current cycle.
- STALL  out  1  pipeline must hold; request inputs stay stable while STALL=1.
- MM_REQ  out  1  main-memory request; held high until MM_ACK.
- MM_WE  out  1  1 = write, 0 = read.
- MM_ADDR  out  32  latched word address, [1:0]=0.
- MM_WDATA  out  32  latched store data.
- MM_RDATA  in  32  fill data; valid only with MM_ACK.
- MM_ACK  in  1  one-cycle completion pulse; ignored unless MM_REQ=1.
- HIT_COUNT  out  CNT_WIDTH  count of load hits, saturating.
- MISS_COUNT  out  CNT_WIDTH  count of load misses, saturating.

Behaviour:
- FSM states: IDLE, RD_MISS, WR_THRU. Reset and power-up state is IDLE.
- Reset (async, at any time including mid-miss):
  - State goes to IDLE; all valid bits clear; counters go to 0.
  - MM_REQ=0, MM_WE=0, MM_ADDR=0, MM_WDATA=0.
  - READ_DATA=0, HIT=0, STALL=0.
  - An outstanding MM_ACK after reset is ignored.
- IDLE, load hit (valid[idx] and tag matches):
  - Combinational response: READ_DATA = line data, HIT=1, STALL=0.
  - HIT_COUNT increments.
- IDLE, load miss:
  - HIT=0, STALL=1, READ_DATA=0.
  - Latch the address; go to RD_MISS; MISS_COUNT increments once per miss.
- IDLE, store (hit or miss):
  - STALL=1, HIT=0.
  - Latch the address and data; go to WR_THRU.
- IDLE, no request: READ_DATA=0, HIT=0, STALL=0.
- RD_MISS:
  - MM_REQ=1, MM_WE=0, STALL=1 until MM_ACK.
  - In the MM_ACK cycle: READ_DATA=MM_RDATA, STALL=0, HIT=0. The line is filled (tag, data, valid=1) at the edge and the state goes to IDLE.
  - The pipeline advances at that same edge, so there is no replay.
- WR_THRU:
  - MM_REQ=1, MM_WE=1, STALL=1 until MM_ACK.
  - In the MM_ACK cycle: STALL=0.
  - At the edge: if the latched tag matched a valid line, update that line's data; a miss allocates nothing. State goes to IDLE.
- Latency: load hit 0 stall cycles; load miss or any store costs 1+W stall cycles, where W = cycles from MM_REQ high to MM_ACK. W=0 is legal (ack in the first MM_REQ cycle).
- MM_REQ, MM_WE, MM_ADDR and MM_WDATA are decoded from the state and latch registers only: glitch-free and independent of the live inputs.
- MM_ADDR and MM_WDATA hold their last value in IDLE.
- Counters saturate at all-ones and never wrap.
- A store to a line always leaves the line consistent with memory, because the line update happens only at ack.

Decomposition:
- Package data_cache_pkg holds:
  - state enum {IDLE, RD_MISS, WR_THRU};
  - localparams TAG_BITS = 30-INDEX_BITS and LINES = 2**INDEX_BITS;
  - index/tag extract functions.
- One sub-module, cache_line_array, provides the tag, valid and data storage:
  - combinational read port;
  - synchronous write port (fill or update);
  - asynchronous valid clear on rst_n.

Test Plan:
- Cold load from 0x0000_0040; memory acks after W=2 with 0xDEAD_BEEF:
  - STALL high 3 cycles, READ_DATA=0xDEAD_BEEF in the ack cycle, MISS_COUNT=1.
  - Repeating the load gives HIT=1, STALL=0, same data, HIT_COUNT=1.
- Store 0x1234_5678 to 0x40 after the fill, W=0:
  - MM_REQ=1, MM_WE=1, MM_ADDR=0x40 for 1 cycle.
  - A following load of 0x40 hits and returns 0x1234_5678.
- Store to uncached 0x0000_0080 (no allocate):
  - A following load of 0x80 misses (MISS_COUNT increments) and issues MM_REQ with MM_WE=0.
- Conflict: load 0x40 then load 0x40+4*2**INDEX_BITS (same index):
  - Both miss; a reload of 0x40 misses again (line evicted).
- Assert rst_n=0 during RD_MISS with MM_REQ=1; ack arrives 1 cycle after release:
  - Outputs return to reset values; the ack is ignored; a load of 0x40 misses (valid cleared).
- MEM_READ and MEM_WRITE both high at 0x40: treated as a store (MM_WE=1), HIT=0, READ_DATA=0.
